// File: rtl/neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq
//
// Sequential fixed-point neuron feeding the softplus activation stage.
//
// A vector of N_INPUTS (x, w) pairs is streamed in over a valid/ready
// handshake. Each pair's sign-magnitude product is accumulated at full
// precision (Q*.2*FRAC) in a signed two's-complement accumulator. The bias is
// folded in with the first pair of each vector, pre-scaled by << FRAC so that
// it lines up with the product scale. Once the last pair is in, one FINAL cycle
// truncates the sum back to Q*.FRAC, saturates it to the sign-magnitude range
// and registers it. The result is then held on a valid/ready handshake until
// the activation stage takes it.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   in_valid   in   x_in / w_in / bias are valid
//   in_ready   out  a pair is accepted this cycle if in_valid is also high
//   x_in       in   activation operand, sign-magnitude Q4.11
//   w_in       in   weight operand, sign-magnitude Q4.11
//   bias       in   bias, sign-magnitude Q4.11, sampled with the first pair only
//   out_valid  out  data_out holds a finished result
//   out_ready  in   downstream consumes data_out while out_valid is high
//   data_out   out  neuron result, sign-magnitude Q4.11 (never -0)
//   busy       out  a vector is in progress
//
// ACC_WIDTH must be at least 2*BITSIZE + clog2(N_INPUTS+1) so the
// accumulator can never wrap. Saturation happens only at conversion.
// -----------------------------------------------------------------------------
module neuron_mac_seq #(
    parameter int BITSIZE   = 16,
    parameter int FRAC      = 11,
    parameter int N_INPUTS  = 8,
    parameter int ACC_WIDTH = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] x_in,
    input  logic [BITSIZE-1:0] w_in,
    input  logic [BITSIZE-1:0] bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] data_out,
    output logic               busy
);

    // Magnitude width of one sign-magnitude word, and of a full product.
    localparam int MAG_W   = BITSIZE - 1;
    localparam int PROD_W  = 2 * MAG_W;
    localparam int CNT_W   = $clog2(N_INPUTS + 1);
    localparam int MAG_MAX = (2 ** MAG_W) - 1;

    localparam logic [CNT_W-1:0]     COUNT_LAST = CNT_W'(N_INPUTS);
    localparam logic [ACC_WIDTH-1:0] SAT_LIMIT  = ACC_WIDTH'(MAG_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        OUTPUT
    } state_t;

    state_t                       state_q,  state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q,    acc_d;
    logic        [CNT_W-1:0]      count_q,  count_d;
    logic        [BITSIZE-1:0]    data_q,   data_d;

    // -------------------------------------------------------------------------
    // Product and bias terms (combinational, valid whenever a pair is offered)
    // -------------------------------------------------------------------------
    logic [MAG_W-1:0]            x_mag;
    logic [MAG_W-1:0]            w_mag;
    logic [PROD_W-1:0]           prod_mag;
    logic                        prod_neg;
    logic signed [ACC_WIDTH-1:0] prod_term;
    logic [ACC_WIDTH-1:0]        bias_mag;
    logic signed [ACC_WIDTH-1:0] bias_term;

    assign x_mag    = x_in[MAG_W-1:0];
    assign w_mag    = w_in[MAG_W-1:0];
    assign prod_mag = PROD_W'(x_mag) * PROD_W'(w_mag);
    // A -0 operand has zero magnitude, so its product is 0 whatever the sign.
    assign prod_neg = x_in[BITSIZE-1] ^ w_in[BITSIZE-1];

    assign prod_term = prod_neg ? -$signed(ACC_WIDTH'(prod_mag))
                                :  $signed(ACC_WIDTH'(prod_mag));

    // Bias is Q*.FRAC; shifting by FRAC brings it to the product's Q*.2*FRAC.
    assign bias_mag  = ACC_WIDTH'({bias[MAG_W-1:0], {FRAC{1'b0}}});
    assign bias_term = bias[BITSIZE-1] ? -$signed(bias_mag) : $signed(bias_mag);

    // -------------------------------------------------------------------------
    // Accumulator to output-word conversion (used in FINAL)
    // -------------------------------------------------------------------------
    logic                 acc_neg;
    logic [ACC_WIDTH-1:0] acc_abs;
    logic [ACC_WIDTH-1:0] acc_shift;
    logic [MAG_W-1:0]     out_mag;
    logic [BITSIZE-1:0]   out_word;

    assign acc_neg   = acc_q[ACC_WIDTH-1];
    assign acc_abs   = acc_neg ? ACC_WIDTH'(-acc_q) : ACC_WIDTH'(acc_q);
    // Shifting the magnitude, not the signed value, truncates toward zero.
    assign acc_shift = acc_abs >> FRAC;
    assign out_mag   = (acc_shift > SAT_LIMIT) ? MAG_W'(MAG_MAX)
                                               : acc_shift[MAG_W-1:0];
    // A zero magnitude is always emitted as +0, never as 0x8000.
    assign out_word  = (out_mag == '0) ? '0 : {acc_neg, out_mag};

    // -------------------------------------------------------------------------
    // Handshake outputs, decoded straight from the state register
    // -------------------------------------------------------------------------
    logic accept;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;
    assign accept    = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // First pair of a vector: the bias enters here, once.
                    acc_d   = bias_term + prod_term;
                    count_d = CNT_W'(1);
                    state_d = (N_INPUTS == 1) ? FINAL : ACCUM;
                end
            end

            ACCUM: begin
                // Without an accept the partial sum and count simply hold.
                if (accept) begin
                    acc_d   = acc_q + prod_term;
                    count_d = count_inc;
                    if (count_inc == COUNT_LAST) begin
                        state_d = FINAL;
                    end
                end
            end

            FINAL: begin
                data_d  = out_word;
                state_d = OUTPUT;
            end

            OUTPUT: begin
                // data_out keeps its value after the handshake; only the
                // accumulation state is cleared for the next vector.
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the whole datapath is reset, not just the FSM, so a reset in the
    // middle of a vector or while a result is pending leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_seq
//
// Self-checking bench for neuron_mac_seq. A transaction-level model watches
// the input and output handshakes, computes each vector's result with plain
// integer arithmetic and predicts in_ready / out_valid / busy / data_out.
// Directed vectors carry hand-computed expected words on top of that.
// -----------------------------------------------------------------------------
module tb_neuron_mac_seq;

    localparam int BITSIZE = 16;
    localparam int FRAC    = 11;
    localparam int N       = 8;

    typedef logic [BITSIZE-1:0] vec_t [N];

    logic               clk       = 1'b0;
    logic               reset     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b0;
    logic [BITSIZE-1:0] x_in      = '0;
    logic [BITSIZE-1:0] w_in      = '0;
    logic [BITSIZE-1:0] bias      = '0;
    logic               in_ready;
    logic               out_valid;
    logic               busy;
    logic [BITSIZE-1:0] data_out;

    int tests = 0;
    int fails = 0;

    neuron_mac_seq #(
        .BITSIZE  (BITSIZE),
        .FRAC     (FRAC),
        .N_INPUTS (N),
        .ACC_WIDTH(40)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: real-valued sign-magnitude arithmetic on integers
    // -------------------------------------------------------------------------
    function automatic longint sm_val(input logic [BITSIZE-1:0] v);
        longint m;
        m = longint'(v[BITSIZE-2:0]);
        return v[BITSIZE-1] ? -m : m;
    endfunction

    function automatic logic [BITSIZE-1:0] model_out(input vec_t xs,
                                                     input vec_t ws,
                                                     input logic [BITSIZE-1:0] b);
        longint s;
        longint a;
        longint m;
        s = sm_val(b) * (longint'(1) << FRAC);
        for (int i = 0; i < N; i++) s += sm_val(xs[i]) * sm_val(ws[i]);
        a = (s < 0) ? -s : s;
        m = a / (longint'(1) << FRAC);
        if (m > 32767) m = 32767;
        if (m == 0) return '0;
        return {(s < 0), m[14:0]};
    endfunction

    // Handshake-level model state.
    vec_t               cur_x;
    vec_t               cur_w;
    logic [BITSIZE-1:0] cur_b    = '0;
    int                 n_col    = 0;
    logic [BITSIZE-1:0] exp_q[$];
    int                 age      = 0;
    logic [BITSIZE-1:0] last_out = '0;

    // One result may be outstanding; while it is, no pair is accepted.
    // It becomes visible one cycle after the last accept.
    task automatic model_step();
        if (!reset) begin
            n_col    = 0;
            exp_q.delete();
            age      = 0;
            last_out = '0;
        end else if (exp_q.size() > 0) begin
            if (age >= 1 && out_ready) last_out = exp_q.pop_front();
            else age++;
        end else if (in_valid) begin
            if (n_col == 0) cur_b = bias;
            cur_x[n_col] = x_in;
            cur_w[n_col] = w_in;
            n_col++;
            if (n_col == N) begin
                exp_q.push_back(model_out(cur_x, cur_w, cur_b));
                n_col = 0;
                age   = 0;
            end
        end
    endtask

    always @(posedge clk or negedge reset) model_step();

    task automatic compare_step();
        logic ov_exp;
        if (!reset) begin
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_data_out", data_out, 16'h0000);
        end else begin
            ov_exp = (exp_q.size() > 0) && (age >= 1);
            check("in_ready", in_ready, exp_q.size() == 0);
            check("out_valid", out_valid, ov_exp);
            check("busy", busy, (n_col > 0) || (exp_q.size() > 0));
            if (ov_exp) check("data_out", data_out, exp_q[0]);
            else        check("data_out_hold", data_out, last_out);
        end
    endtask

    always @(negedge clk) compare_step();

    // -------------------------------------------------------------------------
    // Drivers (inputs change 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic drive_pairs(input vec_t xs, input vec_t ws,
                               input logic [BITSIZE-1:0] b, input int npairs,
                               input bit gaps);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        while (i < npairs) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            x_in     = xs[i];
            w_in     = ws[i];
            // Bias is only meaningful with the first pair; later ones are noise.
            bias     = (i == 0) ? b : 16'h1234;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            budget++;
            if (budget > 400) begin
                check("accept_timeout", 32'(i), 32'(npairs));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [BITSIZE-1:0] want,
                               input int hold, input bit junk);
        int lat  = 0;
        bit seen = 0;
        if (junk) begin
            // Offered during FINAL/OUTPUT; must be ignored.
            in_valid = 1'b1;
            x_in     = 16'h7FFF;
            w_in     = 16'h7FFF;
            bias     = 16'h7FFF;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'd2);
        check(name, data_out, want);
        @(posedge clk);
        #1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_held"}, data_out, want);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vector(input string name, input vec_t xs, input vec_t ws,
                              input logic [BITSIZE-1:0] b,
                              input logic [BITSIZE-1:0] want,
                              input int hold, input bit gaps, input bit junk);
        drive_pairs(xs, ws, b, N, gaps);
        wait_result(name, want, hold, junk);
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    vec_t x_one  = '{default: 16'h0800};
    vec_t w_half = '{default: 16'h0400};
    vec_t w_neg1 = '{default: 16'h8800};
    vec_t w_mix  = '{16'h0800, 16'h0800, 16'h0800, 16'h0800,
                     16'h8800, 16'h8800, 16'h8800, 16'h8800};
    vec_t x_max  = '{default: 16'h7FFF};
    vec_t w_nmax = '{default: 16'hFFFF};
    // 1.5*1 - 0.5*1 + 2*-1.5 + 0*2 + -0*1 + 0.25*2 + -1*-1 + 1*-0.5 = -1.0
    vec_t x_var  = '{16'h0C00, 16'h8400, 16'h1000, 16'h0000,
                     16'h8000, 16'h0200, 16'h8800, 16'h0800};
    vec_t w_var  = '{16'h0800, 16'h0800, 16'h8C00, 16'h1000,
                     16'h0800, 16'h1000, 16'h8800, 16'h8400};
    vec_t x_tiny = '{default: 16'h8001};
    vec_t w_tiny = '{default: 16'h0001};

    initial begin : stimulus
        // Pin the model against hand-computed words.
        check("model_pos4",  model_out(x_one, w_half, 16'h0000), 16'h2000);
        check("model_neg9",  model_out(x_one, w_neg1, 16'h8800), 16'hC800);
        check("model_zero",  model_out(x_one, w_mix,  16'h8000), 16'h0000);
        check("model_sat",   model_out(x_max, x_max,  16'h7FFF), 16'h7FFF);
        check("model_trunc", model_out(x_tiny, w_tiny, 16'h8001), 16'h8001);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_vector("pos4",  x_one, w_half, 16'h0000, 16'h2000, 0, 0, 0);
        run_vector("neg9",  x_one, w_neg1, 16'h8800, 16'hC800, 2, 0, 0);
        run_vector("zero",  x_one, w_mix,  16'h8000, 16'h0000, 0, 0, 0);
        run_vector("mixed", x_var, w_var,  16'h0400, 16'h8400, 1, 0, 0);
        // acc = -(2048 + 8) at Q.22 -> magnitude 1 after truncation toward 0.
        run_vector("trunc", x_tiny, w_tiny, 16'h8001, 16'h8001, 0, 0, 0);
        run_vector("satp",  x_max, x_max,  16'h7FFF, 16'h7FFF, 0, 0, 0);
        run_vector("satn",  x_max, w_nmax, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        run_vector("stall", x_one, w_half, 16'h0000, 16'h2000, 5, 1, 1);
        run_vector("satn2", x_max, w_nmax, 16'hFFFF, 16'hFFFF, 0, 0, 0);

        // Reset after three accepts: immediate return to reset outputs.
        drive_pairs(x_max, x_max, 16'h7FFF, 3, 0);
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_data_out", data_out, 16'h0000);
        check("mid_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_vector("after_rst", x_one, w_half, 16'h0000, 16'h2000, 0, 0, 0);

        // Reset while a result is pending in OUTPUT.
        drive_pairs(x_one, w_neg1, 16'h8800, N, 0);
        @(negedge clk);
        @(negedge clk);
        check("pend_out_valid", out_valid, 1'b1);
        check("pend_data_out", data_out, 16'hC800);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("out_rst_out_valid", out_valid, 1'b0);
        check("out_rst_data_out", data_out, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_vector("after_rst2", x_var, w_var, 16'h0400, 16'h8400, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequential fixed-point neuron that feeds the softplus activation stage. It streams N_INPUTS (input, weight) pairs through a valid/ready handshake and accumulates their products at full precision. It adds a bias, truncates and saturates the sum back to the 16-bit sign-magnitude activation format, then holds the result with a valid/ready handshake until the activation stage takes it.

## Interface
- BITSIZE, 16, word width; sign-magnitude, bit BITSIZE-1 = sign.
- FRAC, 11, fraction bits (Q4.11: 0x0800 = +1.0, 0x8800 = −1.0).
- N_INPUTS, 8, pairs per dot product (≥1).
- ACC_WIDTH, 40, signed accumulator width; must be ≥ 2·BITSIZE + clog2(N_INPUTS+1).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  x_in/w_in/bias valid.
- in_ready  out  1  block accepts a pair this cycle.
- x_in  in  BITSIZE  activation operand.
- w_in  in  BITSIZE  weight operand.
- bias  in  BITSIZE  bias; sampled only with the first pair of a vector.
- out_valid  out  1  data_out holds a finished result.
- out_ready  in  1  downstream consumes data_out.
- data_out  out  BITSIZE  neuron result, sign-magnitude.
- busy  out  1  a vector is in progress (state ≠ IDLE).

## Operation
- Reset (reset=0, async): state IDLE, count 0, accumulator 0. Outputs: in_ready=1, out_valid=0, data_out=0x0000, busy=0.
- Accept happens when in_valid & in_ready at a rising edge.
- Product rule:
  - magnitude = mag(x_in)·mag(w_in), 30 bits unsigned, no shift.
  - sign = sign(x)^sign(w).
  - The product is converted to two's complement and added to the accumulator.
  - −0 (0x8000) on any input is treated as 0.
- Bias rule: added once per vector at the first accept, as the two's-complement value of bias << FRAC.
- States:
  - IDLE: in_ready=1. On accept: acc ← bias_term + product, count ← 1. Next state is FINAL if N_INPUTS=1, else ACCUM.
  - ACCUM: in_ready=1. On accept: acc ← acc + product, count ← count+1. When count reaches N_INPUTS, go to FINAL. No accept means hold.
  - FINAL: in_ready=0. Convert acc to an output word in one cycle, register it into data_out, set out_valid=1, go to OUTPUT.
  - OUTPUT: in_ready=0, out_valid=1, data_out stable. On out_ready, clear out_valid, go to IDLE with acc and count cleared. data_out keeps its last value.
- Conversion in FINAL:
  - s = sign(acc).
  - m = |acc| >> FRAC, truncated toward zero.
  - If m > 2^(BITSIZE−1)−1, then m = 2^(BITSIZE−1)−1 (saturate).
  - If m == 0, output 0x0000; never emit −0.
  - Otherwise output {s, m[BITSIZE−2:0]}.
- The accumulator never wraps, given the ACC_WIDTH constraint. Saturation happens only at conversion.

## Timing
- Throughput: one pair per cycle while in ACCUM/IDLE with in_valid=1.
- Latency: the last pair is accepted at edge t. FINAL runs in cycle t..t+1. out_valid=1 and data_out are valid after edge t+1.
- Minimum vector period is N_INPUTS+2 cycles when out_ready=1 continuously. in_ready returns to 1 in the cycle after the output handshake.
- in_valid gaps in ACCUM only stall; partial sums are kept.
- in_valid during FINAL/OUTPUT is ignored (in_ready=0); upstream must hold the data.
- out_ready while out_valid=0 has no effect.
- Backpressure: out_valid and data_out hold indefinitely until out_ready.
- Reset asserted mid-vector or in OUTPUT takes effect immediately:
  - All partial state is discarded.
  - Outputs return to their reset values.
  - The first accept after deassertion starts a fresh vector with a fresh bias.

## Test plan
- All x=0x0800, all w=0x0400, bias=0x0000, N=8 → data_out=0x2000 (+4.0). out_valid 2 cycles after the 8th accept; busy=1 from the 1st accept until the output handshake.
- All x=0x0800, all w=0x8800, bias=0x8800 → data_out=0xC800 (−9.0).
- Four (0x0800,0x0800) and four (0x0800,0x8800) pairs, bias=0x8000 → data_out=0x0000, not 0x8000.
- All x=w=0x7FFF, bias=0x7FFF → data_out=0x7FFF (saturated). Repeat with w=0xFFFF and bias=0xFFFF → 0xFFFF.
- in_valid toggled randomly and out_ready held low 5 cycles → same result as the unstalled run, data_out constant while stalled, in_ready=0 throughout OUTPUT.
- Reset pulsed low after 3 accepts → out_valid=0, data_out=0x0000 immediately. The next full vector (first test's stimulus) → 0x2000 with no residue from the aborted vector.
